// File: rtl/jt49_mch_if.sv
`default_nettype none
// ------------------------------------------------------------------
// jt49_mch_if : CPU register bus for the multi-channel PSG core
// Rev 1.0
// ------------------------------------------------------------------
interface jt49_mch_if;
  logic       cs_n;
  logic       wr_n;
  logic [4:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output wr_n, output addr, output din, input dout);
  modport slave  (input cs_n, input wr_n, input addr, input din, output dout);
endinterface
`default_nettype wire

// File: rtl/jt49_mch.sv
`default_nettype none
// ------------------------------------------------------------------
// jt49_mch : parametrised multi-channel PSG (tone, shared noise/envelope)
// Rev 1.0
// ------------------------------------------------------------------
module jt49_mch #(
  parameter int CH = 3,
  parameter int TW = 12,
  parameter int SW = 8 + $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  jt49_mch_if.slave       bus,
  output logic [8*CH-1:0] ch_lin,
  output logic [SW-1:0]   sound
);

  logic [CH-1:0][TW-1:0] per_q, per_d;
  logic [CH-1:0][4:0]    vol_q, vol_d;
  logic [CH-1:0]         tdis_q, tdis_d, ndis_q, ndis_d;
  logic [4:0]            nper_q, nper_d;
  logic [15:0]           eper_q, eper_d;
  logic [3:0]            shape_q, shape_d;
  logic [7:0]            dout_q, dout_d;
  logic [2:0]            pre_q, pre_d;
  logic [CH-1:0][TW-1:0] tcnt_q, tcnt_d;
  logic [CH-1:0]         tone_q, tone_d;
  logic [4:0]            ncnt_q, ncnt_d;
  logic [16:0]           lfsr_q, lfsr_d;
  logic [15:0]           ediv_q, ediv_d;
  logic [4:0]            ecnt_q, ecnt_d;
  logic                  einv_q, einv_d, ehold_q, ehold_d, ezero_q, ezero_d;
  logic [CH-1:0]         mix_q, mix_d;
  logic [CH-1:0][4:0]    log_q, log_d;
  logic [SW-1:0]         sound_q, sound_d;

  logic       wr_en, env_restart, tick, nshift, estep;
  logic [7:0] rd_val;
  logic [4:0] env;
  logic [SW-1:0] sum;

  // Wrap limit: a period of 0 behaves like a period of 1.
  function automatic logic [15:0] lim16(input logic [15:0] p);
    return (p == 16'd0) ? 16'd0 : p - 16'd1;
  endfunction

  // ~1.5 dB per step, 0 is silence and 31 is full scale.
  function automatic logic [7:0] jt49_exp(input logic [4:0] l);
    logic [7:0] v;
    case (l)
      5'd0:  v = 8'd0;    5'd1:  v = 8'd1;    5'd2:  v = 8'd2;    5'd3:  v = 8'd2;
      5'd4:  v = 8'd2;    5'd5:  v = 8'd3;    5'd6:  v = 8'd3;    5'd7:  v = 8'd4;
      5'd8:  v = 8'd5;    5'd9:  v = 8'd6;    5'd10: v = 8'd7;    5'd11: v = 8'd8;
      5'd12: v = 8'd10;   5'd13: v = 8'd11;   5'd14: v = 8'd14;   5'd15: v = 8'd16;
      5'd16: v = 8'd19;   5'd17: v = 8'd23;   5'd18: v = 8'd27;   5'd19: v = 8'd32;
      5'd20: v = 8'd38;   5'd21: v = 8'd45;   5'd22: v = 8'd54;   5'd23: v = 8'd64;
      5'd24: v = 8'd76;   5'd25: v = 8'd90;   5'd26: v = 8'd108;  5'd27: v = 8'd128;
      5'd28: v = 8'd152;  5'd29: v = 8'd181;  5'd30: v = 8'd215;  default: v = 8'd255;
    endcase
    return v;
  endfunction

  // Register file: reads sample the pre-write value, so a same-cycle R/W returns old data.
  always_comb begin
    wr_en       = !bus.cs_n && !bus.wr_n;
    per_d       = per_q;
    vol_d       = vol_q;
    tdis_d      = tdis_q;
    ndis_d      = ndis_q;
    nper_d      = nper_q;
    eper_d      = eper_q;
    shape_d     = shape_q;
    env_restart = 1'b0;
    rd_val      = 8'h00;
    for (int i = 0; i < CH; i++) begin
      if (bus.addr == 5'(2*i)) begin
        rd_val = per_q[i][7:0];
        if (wr_en) per_d[i] = (per_q[i] & ~TW'(8'hFF)) | TW'(bus.din);
      end
      if (bus.addr == 5'(2*i+1)) begin
        rd_val = 8'(per_q[i] >> 8);
        if (wr_en) per_d[i] = TW'({bus.din, per_q[i][7:0]});
      end
      if (bus.addr == 5'(16+i)) begin
        rd_val = 8'(vol_q[i]);
        if (wr_en) vol_d[i] = bus.din[4:0];
      end
    end
    case (bus.addr)
      5'h18: begin rd_val = 8'(tdis_q);      if (wr_en) tdis_d = bus.din[CH-1:0]; end
      5'h19: begin rd_val = 8'(ndis_q);      if (wr_en) ndis_d = bus.din[CH-1:0]; end
      5'h1A: begin rd_val = 8'(nper_q);      if (wr_en) nper_d = bus.din[4:0]; end
      5'h1B: begin rd_val = eper_q[7:0];     if (wr_en) eper_d[7:0] = bus.din; end
      5'h1C: begin rd_val = eper_q[15:8];    if (wr_en) eper_d[15:8] = bus.din; end
      5'h1D: begin
        rd_val = 8'(shape_q);
        if (wr_en) begin
          shape_d     = bus.din[3:0];
          env_restart = 1'b1;
        end
      end
      default: ;
    endcase
    dout_d = bus.cs_n ? dout_q : rd_val;
  end

  // Prescaler, tone counters and noise LFSR
  always_comb begin
    tick   = cen && (pre_q == 3'd7);
    pre_d  = cen ? pre_q + 3'd1 : pre_q;
    tcnt_d = tcnt_q;
    tone_d = tone_q;
    ncnt_d = ncnt_q;
    lfsr_d = lfsr_q;
    nshift = 1'b0;
    if (tick) begin
      for (int i = 0; i < CH; i++) begin
        if (16'(tcnt_q[i]) >= lim16(16'(per_q[i]))) begin
          tcnt_d[i] = '0;
          tone_d[i] = ~tone_q[i];
        end else begin
          tcnt_d[i] = tcnt_q[i] + TW'(1);
        end
      end
      if (16'(ncnt_q) >= lim16(16'(nper_q))) begin
        ncnt_d = 5'd0;
        nshift = 1'b1;
      end else begin
        ncnt_d = ncnt_q + 5'd1;
      end
    end
    if (nshift) lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
  end

  // Envelope; a shape write overrides any step in the same cycle.
  always_comb begin
    ediv_d  = ediv_q;
    ecnt_d  = ecnt_q;
    einv_d  = einv_q;
    ehold_d = ehold_q;
    ezero_d = ezero_q;
    estep   = 1'b0;
    if (env_restart) begin
      ediv_d  = 16'd0;
      ecnt_d  = 5'd0;
      einv_d  = 1'b0;
      ehold_d = 1'b0;
      ezero_d = 1'b0;
    end else if (tick) begin
      if (ediv_q >= lim16(eper_q)) begin
        ediv_d = 16'd0;
        estep  = 1'b1;
      end else begin
        ediv_d = ediv_q + 16'd1;
      end
      if (estep && !ehold_q) begin
        if (ecnt_q != 5'd31) begin
          ecnt_d = ecnt_q + 5'd1;
        end else if (!shape_q[3]) begin
          ehold_d = 1'b1;
          ezero_d = 1'b1;
        end else if (shape_q[0]) begin
          ehold_d = 1'b1;
          einv_d  = einv_q ^ shape_q[1];
        end else begin
          ecnt_d = 5'd0;
          einv_d = einv_q ^ shape_q[1];
        end
      end
    end
    env = ezero_q ? 5'd0 : ((shape_q[2] ^ einv_q) ? ecnt_q : 5'd31 - ecnt_q);
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign ch_lin[8*gi +: 8] = jt49_exp(log_q[gi]);
  end

  // Three-stage output pipeline: mix, log level, sum.
  always_comb begin
    mix_d   = mix_q;
    log_d   = log_q;
    sound_d = sound_q;
    sum     = '0;
    for (int i = 0; i < CH; i++) sum = sum + SW'(ch_lin[8*i +: 8]);
    if (cen) begin
      mix_d = (tone_q | tdis_q) & ({CH{lfsr_q[0]}} | ndis_q);
      for (int i = 0; i < CH; i++)
        log_d[i] = !mix_q[i] ? 5'd0 : (vol_q[i][4] ? env : {vol_q[i][3:0], vol_q[i][3]});
      sound_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q   <= '0;
      vol_q   <= '0;
      tdis_q  <= '0;
      ndis_q  <= '0;
      nper_q  <= '0;
      eper_q  <= '0;
      shape_q <= '0;
      dout_q  <= '0;
      pre_q   <= '0;
      tcnt_q  <= '0;
      tone_q  <= '0;
      ncnt_q  <= '0;
      lfsr_q  <= 17'h1;
      ediv_q  <= '0;
      ecnt_q  <= '0;
      einv_q  <= 1'b0;
      ehold_q <= 1'b1;
      ezero_q <= 1'b1;
      mix_q   <= '0;
      log_q   <= '0;
      sound_q <= '0;
    end else begin
      per_q   <= per_d;
      vol_q   <= vol_d;
      tdis_q  <= tdis_d;
      ndis_q  <= ndis_d;
      nper_q  <= nper_d;
      eper_q  <= eper_d;
      shape_q <= shape_d;
      dout_q  <= dout_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
      ncnt_q  <= ncnt_d;
      lfsr_q  <= lfsr_d;
      ediv_q  <= ediv_d;
      ecnt_q  <= ecnt_d;
      einv_q  <= einv_d;
      ehold_q <= ehold_d;
      ezero_q <= ezero_d;
      mix_q   <= mix_d;
      log_q   <= log_d;
      sound_q <= sound_d;
    end
  end

  assign bus.dout = dout_q;
  assign sound    = sound_q;

endmodule
`default_nettype wire

// File: tb/tb_jt49_mch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_jt49_mch : directed bench for jt49_mch (CH=3 main, CH=8 / CH=1 sum width)
// Rev 1.0
// ------------------------------------------------------------------
module tb_jt49_mch;
  logic clk = 1'b0;
  logic rst_n;
  logic cen;
  always #5 clk = ~clk;

  jt49_mch_if bus3 ();
  jt49_mch_if bus8 ();
  jt49_mch_if bus1 ();

  logic [23:0] ch_lin3;
  logic [9:0]  sound3;
  logic [63:0] ch_lin8;
  logic [10:0] sound8;
  logic [7:0]  ch_lin1;
  logic [7:0]  sound1;

  jt49_mch #(.CH(3)) u_dut  (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus3), .ch_lin(ch_lin3), .sound(sound3));
  jt49_mch #(.CH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus8), .ch_lin(ch_lin8), .sound(sound8));
  jt49_mch #(.CH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus1), .ch_lin(ch_lin1), .sound(sound1));

  // 255 * 10^(-1.5dB*(31-l)/20), rounded; level 0 is silence
  localparam logic [7:0] LIN [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic wr, input logic [4:0] a, input logic [7:0] d);
    bus3.cs_n = cs; bus3.wr_n = wr; bus3.addr = a; bus3.din = d;
    bus8.cs_n = cs; bus8.wr_n = wr; bus8.addr = a; bus8.din = d;
    bus1.cs_n = cs; bus1.wr_n = wr; bus1.addr = a; bus1.din = d;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, a, d);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 5'd0, 8'd0);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, a, 8'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 5'd0, 8'd0);
    v = bus3.dout;
  endtask

  task automatic do_reset();
    cen = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Sync to an edge of ch0, then check several half-periods of length 'half' clk.
  task automatic measure(input string tag, input int half, input int runs);
    logic [7:0] prev;
    int n;
    bit ok;
    prev = ch_lin3[7:0];
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(posedge clk); #1; n++;
      if (ch_lin3[7:0] != prev) ok = 1'b1;
    end
    chk({tag, "_sync"}, 64'(ok), 64'd1);
    for (int r = 0; r < runs; r++) begin
      prev = ch_lin3[7:0];
      ok = 1'b0;
      n = 0;
      while (!ok && n < 200) begin
        @(posedge clk); #1; n++;
        if (ch_lin3[7:0] != prev) ok = 1'b1;
      end
      chk({tag, "_half"}, 64'(n), 64'(half));
      chk({tag, "_level"}, 64'(ch_lin3[7:0]), (prev == 8'd0) ? 64'd255 : 64'd0);
    end
  endtask

  function automatic int env_seq(input logic [3:0] s, input int n);
    if (s == 4'hE) return (n <= 31) ? n : ((n <= 63) ? 63 - n : n - 64);
    if (s == 4'hB) return (n <= 31) ? 31 - n : 31;
    return (n <= 31) ? 31 - n : 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [16:0] m;
    logic [3:0]  shp;
    bit ok;
    int n;

    rst_n = 1'b0;
    cen   = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_dout", 64'(bus3.dout), 64'd0);
    chk("rst_chlin", 64'(ch_lin3), 64'd0);
    chk("rst_sound", 64'(sound3), 64'd0);
    chk("rst_lfsr", 64'(u_dut.lfsr_q), 64'd1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), v);
      chk($sformatf("rst_reg%02h", a), 64'(v), 64'd0);
    end

    // Readback masking
    wr(5'h01, 8'hFF); rd(5'h01, v); chk("mask_01", 64'(v), 64'h0F);
    wr(5'h10, 8'hFF); rd(5'h10, v); chk("mask_10", 64'(v), 64'h1F);
    wr(5'h18, 8'hFF); rd(5'h18, v); chk("mask_18", 64'(v), 64'h07);
    wr(5'h1A, 8'hFF); rd(5'h1A, v); chk("mask_1A", 64'(v), 64'h1F);
    wr(5'h1D, 8'hFF); rd(5'h1D, v); chk("mask_1D", 64'(v), 64'h0F);
    wr(5'h1F, 8'hFF); rd(5'h1F, v); chk("mask_1F", 64'(v), 64'h00);

    // Simultaneous read and write returns the old value
    wr(5'h00, 8'h55);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 5'h00, 8'hAA);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 5'd0, 8'd0);
    chk("rw_same_old", 64'(bus3.dout), 64'h55);
    rd(5'h00, v); chk("rw_same_new", 64'(v), 64'hAA);

    // Tone period
    do_reset();
    cen = 1'b1;
    wr(5'h00, 8'h02); wr(5'h01, 8'h00);
    wr(5'h18, 8'h06); wr(5'h19, 8'h07); wr(5'h10, 8'h0F);
    measure("tone_p2", 16, 3);
    chk("tone_other_ch", 64'(ch_lin3[23:8]), 64'd0);
    wr(5'h00, 8'h00);
    measure("tone_p0", 8, 3);
    wr(5'h00, 8'h01);
    measure("tone_p1", 8, 3);

    // Summed output and asynchronous reset mid-tone
    rd(5'h10, v); chk("rd_vol0", 64'(v), 64'h0F);
    ok = 1'b0; n = 0;
    while (!ok && n < 100) begin
      @(posedge clk); #1; n++;
      if (ch_lin3[7:0] == 8'd255) ok = 1'b1;
    end
    chk("tone_high_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    chk("tone_sound", 64'(sound3), 64'd255);
    #3 rst_n = 1'b0;
    #1;
    chk("async_dout", 64'(bus3.dout), 64'd0);
    chk("async_chlin", 64'(ch_lin3), 64'd0);
    chk("async_sound", 64'(sound3), 64'd0);
    cen = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_lfsr", 64'(u_dut.lfsr_q), 64'd1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), v);
      chk($sformatf("post_rst_reg%02h", a), 64'(v), 64'd0);
    end

    // Envelope shapes
    for (int si = 0; si < 3; si++) begin
      shp = (si == 0) ? 4'hE : ((si == 1) ? 4'hB : 4'h0);
      do_reset();
      wr(5'h1B, 8'h01); wr(5'h1C, 8'h00); wr(5'h10, 8'h10);
      wr(5'h18, 8'h07); wr(5'h19, 8'h07); wr(5'h1D, 8'(shp));
      @(posedge clk); #1 cen = 1'b1;
      ok = 1'b0; n = 0;
      while (!ok && n < 40) begin
        @(posedge clk); #1; n++;
        if (ch_lin3[7:0] == LIN[env_seq(shp, 1)]) ok = 1'b1;
      end
      chk($sformatf("env%h_sync", shp), 64'(ok), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      for (int k = 1; k <= ((shp == 4'hE) ? 70 : 40); k++) begin
        chk($sformatf("env%h_step%0d", shp, k), 64'(ch_lin3[7:0]), 64'(LIN[env_seq(shp, k)]));
        repeat (8) @(posedge clk);
        #1;
      end
    end

    // Noise: channel 0 follows the LFSR output bit
    do_reset();
    wr(5'h19, 8'h06); wr(5'h18, 8'h07); wr(5'h1A, 8'h01); wr(5'h10, 8'h0F);
    @(posedge clk); #1 cen = 1'b1;
    m = 17'h1;
    for (int j = 0; j < 40; j++) begin
      repeat ((j == 0) ? 5 : 8) @(posedge clk);
      #1;
      chk($sformatf("noise_bit%0d", j), 64'(ch_lin3[7:0]), m[0] ? 64'd255 : 64'd0);
      if (j < 8) chk($sformatf("noise_first%0d", j), 64'(ch_lin3[7:0]), (j == 0) ? 64'd255 : 64'd0);
      m = {m[0] ^ m[3], m[16:1]};
    end
    chk("noise_other_ch", 64'(ch_lin3[23:8]), 64'd0);

    // Sum width across channel counts
    do_reset();
    for (int a = 16; a < 24; a++) wr(5'(a), 8'h0F);
    wr(5'h18, 8'hFF); wr(5'h19, 8'hFF);
    cen = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sum_ch8", 64'(sound8), 64'd2040);
    chk("sum_ch1", 64'(sound1), 64'd255);
    chk("sum_ch3", 64'(sound3), 64'd765);
    chk("lin_ch8", ch_lin8, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
